// File: rtl/apb3_slave_mem_if.sv
// APB3 bus bundle between a requester and the register-file completer.
// The master modport drives the request side; the slave modport returns the response.
interface apb3_slave_mem_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb3_slave_mem.sv
// APB3 completer backed by DEPTH x 32-bit registers, with fixed wait states,
// and an error response for misaligned or out-of-range addresses.
module apb3_slave_mem #(
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    apb3_slave_mem_if.slave    bus
);
    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [4:0] WAIT5 = 5'(WAIT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state_reg,   state_next;
    logic [3:0]         cnt_reg,     cnt_next;
    logic               pwrite_reg,  pwrite_next;
    logic               err_reg,     err_next;
    logic [IDX_W-1:0]   idx_reg,     idx_next;
    logic [31:0]        pwdata_reg,  pwdata_next;
    logic [31:0]        prdata_reg,  prdata_next;
    logic               pready_reg,  pready_next;
    logic               pslverr_reg, pslverr_next;

    logic [31:0]        mem_reg [DEPTH];
    logic [DEPTH-1:0]   we_vec;

    logic [31:0]        off;
    logic               dec_err;
    logic [IDX_W-1:0]   dec_idx;
    logic [4:0]         cnt_inc;
    logic               mem_we;
    logic               load;
    logic               load_wr;
    logic               load_err;
    logic [IDX_W-1:0]   load_idx;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land out of range.
    always_comb begin
        off     = bus.paddr - BASE_ADDR;
        dec_err = (bus.paddr[1:0] != 2'b00) || ((off >> 2) >= 32'(DEPTH));
        dec_idx = off[IDX_W+1:2];
        cnt_inc = {1'b0, cnt_reg} + 5'd1;
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pwrite_next  = pwrite_reg;
        err_next     = err_reg;
        idx_next     = idx_reg;
        pwdata_next  = pwdata_reg;
        prdata_next  = prdata_reg;
        pready_next  = pready_reg;
        pslverr_next = pslverr_reg;
        mem_we       = 1'b0;
        load         = 1'b0;
        load_wr      = pwrite_reg;
        load_err     = err_reg;
        load_idx     = idx_reg;

        case (state_reg)
            IDLE: begin
                prdata_next  = '0;
                pready_next  = 1'b0;
                pslverr_next = 1'b0;
                if (bus.psel && !bus.penable) begin
                    state_next  = ACCESS;
                    cnt_next    = '0;
                    pwrite_next = bus.pwrite;
                    err_next    = dec_err;
                    idx_next    = dec_idx;
                    pwdata_next = bus.pwdata;
                    if (WAIT_CYCLES == 0) begin
                        load     = 1'b1;
                        load_wr  = bus.pwrite;
                        load_err = dec_err;
                        load_idx = dec_idx;
                    end
                end
            end
            ACCESS: begin
                if (!bus.psel) begin
                    // Requester walked away: abort takes priority, nothing is written.
                    state_next   = IDLE;
                    cnt_next     = '0;
                    prdata_next  = '0;
                    pready_next  = 1'b0;
                    pslverr_next = 1'b0;
                end else if (pready_reg) begin
                    if (bus.penable) begin
                        mem_we       = pwrite_reg && !err_reg;
                        state_next   = IDLE;
                        prdata_next  = '0;
                        pready_next  = 1'b0;
                        pslverr_next = 1'b0;
                    end
                end else if (bus.penable) begin
                    cnt_next = cnt_inc[3:0];
                    if (cnt_inc == WAIT5) begin
                        load = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            pready_next  = 1'b1;
            pslverr_next = load_err;
            prdata_next  = (!load_wr && !load_err) ? mem_reg[load_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            pwrite_reg  <= 1'b0;
            err_reg     <= 1'b0;
            idx_reg     <= '0;
            pwdata_reg  <= '0;
            prdata_reg  <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pwrite_reg  <= pwrite_next;
            err_reg     <= err_next;
            idx_reg     <= idx_next;
            pwdata_reg  <= pwdata_next;
            prdata_reg  <= prdata_next;
            pready_reg  <= pready_next;
            pslverr_reg <= pslverr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign we_vec[gi] = mem_we && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    // The register file must clear on reset, so it is built from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we_vec[i]) begin
                    mem_reg[i] <= pwdata_reg;
                end
            end
        end
    end

    assign bus.prdata  = prdata_reg;
    assign bus.pready  = pready_reg;
    assign bus.pslverr = pslverr_reg;

endmodule

// File: tb/tb_apb3_slave_mem.sv
// Directed bench for apb3_slave_mem: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance
// share the clock/reset; expected responses are queued at setup and checked at pready.
module tb_apb3_slave_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    bit          use_w0 = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          en_cycles;
    } exp_t;

    exp_t sb[$];

    apb3_slave_mem_if bus_w2 ();
    apb3_slave_mem_if bus_w0 ();

    assign bus_w2.psel    = psel && !use_w0;
    assign bus_w2.penable = penable;
    assign bus_w2.pwrite  = pwrite;
    assign bus_w2.paddr   = paddr;
    assign bus_w2.pwdata  = pwdata;
    assign bus_w0.psel    = psel && use_w0;
    assign bus_w0.penable = penable;
    assign bus_w0.pwrite  = pwrite;
    assign bus_w0.paddr   = paddr;
    assign bus_w0.pwdata  = pwdata;

    wire [31:0] obs_prdata  = use_w0 ? bus_w0.prdata  : bus_w2.prdata;
    wire        obs_pready  = use_w0 ? bus_w0.pready  : bus_w2.pready;
    wire        obs_pslverr = use_w0 ? bus_w0.pslverr : bus_w2.pslverr;

    apb3_slave_mem #(.DEPTH(16), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut_w2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w2)
    );

    apb3_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transfer starting right now; returns just after the completion edge so a
    // following call produces a back-to-back setup with no idle cycle.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rdata,
                        input logic exp_err);
        exp_t e;
        int   en_cycles;
        bit   done;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        sb.push_back('{tag, exp_rdata, exp_err, use_w0 ? 1 : 3});
        @(posedge clk); #1;
        penable   = 1'b1;
        en_cycles = 0;
        done      = 1'b0;
        while (!done && en_cycles < 40) begin
            en_cycles++;
            if (obs_pready) begin
                done = 1'b1;
                e = sb.pop_front();
                check({e.tag, "_prdata"},  obs_prdata, e.rdata);
                check({e.tag, "_pslverr"}, 32'(obs_pslverr), 32'(e.err));
                check({e.tag, "_cycles"},  32'(en_cycles), 32'(e.en_cycles));
                $display("xfer %-12s %s addr=%h wdata=%h prdata=%h pslverr=%0d penable_cycles=%0d",
                         tag, wr ? "WR" : "RD", addr, data, obs_prdata, obs_pslverr, en_cycles);
            end
            @(posedge clk); #1;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        // Reset state of both instances
        repeat (3) @(posedge clk);
        #1;
        check("rst_w2_pready",  32'(bus_w2.pready),  32'd0);
        check("rst_w2_pslverr", 32'(bus_w2.pslverr), 32'd0);
        check("rst_w2_prdata",  bus_w2.prdata,       32'd0);
        check("rst_w0_pready",  32'(bus_w0.pready),  32'd0);
        check("rst_w0_pslverr", 32'(bus_w0.pslverr), 32'd0);
        check("rst_w0_prdata",  bus_w0.prdata,       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: write then read with two wait states
        xfer("t1_wr08", 1'b1, 32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xfer("t1_rd08", 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // 2: back-to-back writes then reads, including the last register
        xfer("t2_wr00", 1'b1, 32'h00, 32'h11, 32'h0, 1'b0);
        xfer("t2_wr04", 1'b1, 32'h04, 32'h22, 32'h0, 1'b0);
        xfer("t2_wr3c", 1'b1, 32'h3C, 32'h33, 32'h0, 1'b0);
        xfer("t2_rd00", 1'b0, 32'h00, 32'h0, 32'h11, 1'b0);
        xfer("t2_rd04", 1'b0, 32'h04, 32'h0, 32'h22, 1'b0);
        xfer("t2_rd3c", 1'b0, 32'h3C, 32'h0, 32'h33, 1'b0);

        // 3: out-of-range read, misaligned write, memory untouched
        xfer("t3_rd40",  1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
        xfer("t3_wr06",  1'b1, 32'h06, 32'h1234_5678, 32'h0, 1'b1);
        xfer("t3_rd04",  1'b0, 32'h04, 32'h0, 32'h22, 1'b0);
        xfer("t3_rdfc",  1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);

        // 4: abort after one access cycle
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFE;
        @(posedge clk); #1;
        penable = 1'b1;
        check("t4_acc1_pready", 32'(obs_pready), 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check("t4_abort_pready", 32'(obs_pready), 32'd0);
        @(posedge clk); #1;
        check("t4_abort_pready2", 32'(obs_pready), 32'd0);
        xfer("t4_rd10",  1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        xfer("t4_wr14",  1'b1, 32'h14, 32'h0BAD_F00D, 32'h0, 1'b0);
        xfer("t4_rd14",  1'b0, 32'h14, 32'h0, 32'h0BAD_F00D, 1'b0);

        // 6: zero wait states
        use_w0 = 1'b1;
        @(posedge clk); #1;
        xfer("t6_wr04", 1'b1, 32'h04, 32'hA5A5_0004, 32'h0, 1'b0);
        xfer("t6_rd04", 1'b0, 32'h04, 32'h0, 32'hA5A5_0004, 1'b0);
        xfer("t6_rd40", 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
        use_w0 = 1'b0;
        @(posedge clk); #1;

        // 5: reset while the write response is being presented
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_pre_pready", 32'(obs_pready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_pready",  32'(obs_pready),  32'd0);
        check("t5_rst_pslverr", 32'(obs_pslverr), 32'd0);
        check("t5_rst_prdata",  obs_prdata,       32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer("t5_rd0c", 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0);
        xfer("t5_rd08", 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
        use_w0 = 1'b1;
        xfer("t5_w0rd04", 1'b0, 32'h04, 32'h0, 32'h0, 1'b0);
        use_w0 = 1'b0;

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
